cv32e40p_tb_data_arbiter: RTL

Two-master arbiter for the testbench data memory port. It shares the single data port of the memory-mapped RAM between the core LSU (master 0) and a testbench-side loader/checker agent (master 1). The agent uses the port to inject stimulus and read back results while the core runs. It sits between the core/agent and the RAM, and speaks the core's req/gnt/rvalid protocol on every side. It does round-robin arbitration, holds a request stable until it is granted, tracks in-order outstanding responses and routes each response back to its issuer.

---
 rtl/cv32e40p_tb_data_arbiter_if.sv | 41 ++++
 rtl/cv32e40p_tb_data_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tb_data_arbiter_if.sv
// ---------------------------------------------------------------------------
// cv32e40p_tb_data_arbiter_if
//
// Purpose: one req/gnt/rvalid data-port bundle, as spoken by the core LSU,
// the testbench agent and the data RAM.
//
// Signals:
//   req    master -> slave  request valid, held until gnt
//   addr   master -> slave  byte address
//   we     master -> slave  1 = write, 0 = read
//   be     master -> slave  byte enables (DATA_WIDTH/8)
//   wdata  master -> slave  write data
//   gnt    slave -> master  request accepted this cycle
//   rvalid slave -> master  in-order response (reads and writes)
//   rdata  slave -> master  read data, qualified by rvalid
//
// Modports: master = request issuer, slave = request acceptor.
// ---------------------------------------------------------------------------
interface cv32e40p_tb_data_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/cv32e40p_tb_data_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_tb_data_arbiter
//
// Purpose: shares the single data port of the testbench RAM between the core
// LSU (m0) and a testbench loader/checker agent (m1). Round-robin between the
// two, a stalled request is frozen on the RAM side until granted, and the
// issuer of every granted transaction is kept in an in-order ID FIFO so each
// rvalid is routed back to the right master.
//
// Handshake: a master raises req with stable fields and keeps them until it
// sees gnt in the same cycle; every granted transaction (read or write) is
// answered by exactly one rvalid, in grant order.
//
// Ports:
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   m0, m1              slave side of the core / agent bundles
//   s                   master side towards the RAM
//   outstanding_o       granted-but-unanswered transaction count
//   err_unexp_rvalid_o  sticky: rvalid received with nothing outstanding
//   state_o             debug view of the FSM (0 = ARB, 1 = HOLD)
// ---------------------------------------------------------------------------
module cv32e40p_tb_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    cv32e40p_tb_data_arbiter_if.slave         m0,
    cv32e40p_tb_data_arbiter_if.slave         m1,
    cv32e40p_tb_data_arbiter_if.master        s,
    output logic [CNT_W-1:0]                  outstanding_o,
    output logic                              err_unexp_rvalid_o,
    output logic                              state_o
);

    localparam int                PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     r_state;
    logic                       r_hold_sel;
    logic                       r_last;
    logic [CNT_W-1:0]           r_count;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic                       r_err;

    logic                       w_full;
    logic                       w_sel;
    logic                       w_sel_req;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head;

    assign w_full = (r_count == CNT_MAX);

    // Winner selection. In HOLD the stalled master stays selected regardless
    // of what the other master does; in ARB a tie goes to the master that was
    // not granted last.
    always_comb begin
        w_sel = 1'b0;
        if (r_state == ST_HOLD) begin
            w_sel = r_hold_sel;
        end else if (m0.req && m1.req) begin
            w_sel = ~r_last;
        end else if (m1.req) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_req = w_sel ? m1.req : m0.req;

    // Full gates the request using the registered count only, so a pop in
    // the same cycle never reaches s.req through a comb path.
    assign s.req   = w_sel_req & ~w_full;
    assign s.addr  = w_sel ? m1.addr  : m0.addr;
    assign s.we    = w_sel ? m1.we    : m0.we;
    assign s.be    = w_sel ? m1.be    : m0.be;
    assign s.wdata = w_sel ? m1.wdata : m0.wdata;

    assign w_push = s.req & s.gnt;
    assign m0.gnt = w_push & ~w_sel;
    assign m1.gnt = w_push &  w_sel;

    // Responses with nothing outstanding are flagged and otherwise dropped.
    assign w_head    = r_fifo[r_rptr];
    assign w_pop     = s.rvalid & (r_count != '0);
    assign m0.rvalid = w_pop & ~w_head;
    assign m1.rvalid = w_pop &  w_head;
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    assign outstanding_o      = r_count;
    assign err_unexp_rvalid_o = r_err;
    assign state_o            = (r_state == ST_HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_ARB;
            r_hold_sel <= 1'b0;
            r_last     <= 1'b1;
            r_count    <= '0;
            r_fifo     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (s.req && !s.gnt) begin
                        r_state    <= ST_HOLD;
                        r_hold_sel <= w_sel;
                    end
                end
                ST_HOLD: begin
                    // Leave on grant, or when the held master withdraws its
                    // request (a protocol violation on its side).
                    if (w_push || !w_sel_req) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase

            if (w_push) begin
                r_last         <= w_sel;
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= (r_wptr == PTR_MAX) ? '0 : r_wptr + 1'b1;
            end

            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + 1'b1;
            end

            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (s.rvalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
